// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops PAR_READ-lane FIFO words and emits them one element per beat.
// Define READER_PREFETCH_EN to pop the next word on the last-lane handshake and skip the FETCH bubble.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_READ   = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           total_len,
  input  logic                           fifo_valid,
  input  logic [DATA_WIDTH*PAR_READ-1:0] fifo_data,
  output logic                           fifo_ren,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic [LEN_WIDTH-1:0]           elem_count
);
  localparam int LW = PAR_READ > 1 ? $clog2(PAR_READ) : 1;
  localparam logic [LW-1:0] LAST = LW'(PAR_READ - 1);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  state_t                         state_q, state_d;
  logic [DATA_WIDTH*PAR_READ-1:0] word_q, word_d;
  logic [LW-1:0]                  lane_q, lane_d;
  logic [LEN_WIDTH-1:0]           cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic                           hs;
  always_comb begin
    cnt_inc  = cnt_q + LEN_WIDTH'(1);
    hs       = state_q == EMIT && out_ready;
    state_d  = state_q;
    word_d   = word_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    fifo_ren = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = total_len;
        cnt_d   = '0;
        state_d = total_len == '0 ? DONE : FETCH;
      end
      FETCH: begin
        fifo_ren = fifo_valid;
        if (fifo_valid) begin
          word_d  = fifo_data;
          lane_d  = '0;
          state_d = EMIT;
        end
      end
      EMIT: if (hs) begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) state_d = DONE;
        else if (lane_q == LAST) begin
`ifdef READER_PREFETCH_EN
          fifo_ren = fifo_valid;
          if (fifo_valid) begin
            word_d = fifo_data;
            lane_d = '0;
          end
          state_d = fifo_valid ? EMIT : FETCH;
`else
          state_d = FETCH;
`endif
        end else lane_d = lane_q + LW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  assign out_valid  = state_q == EMIT;
  assign out_data   = DATA_WIDTH'(word_q >> (DATA_WIDTH * lane_q));
  assign busy       = state_q == FETCH || state_q == EMIT;
  assign done       = state_q == DONE;
  assign elem_count = cnt_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed tests against a queue-based stream model of the reader (PAR_READ=2).
module tb_fifo_stream_reader;
  localparam int DW = 16, P = 2, LW = 16;
  logic clk = 0, rst_n = 0, start = 0, fifo_en = 1, out_ready = 1;
  logic [LW-1:0] total_len = '0;
  logic fifo_valid, fifo_ren, out_valid, busy, done;
  logic [DW*P-1:0] fifo_data;
  logic [DW-1:0] out_data;
  logic [LW-1:0] elem_count;
  logic [DW*P-1:0] mem [16];
  int rd = 0, wr = 0, pops = 0, total = 0, bad = 0;
  int m_ph = 0, m_cnt = 0, m_len = 0, m_pops = 0;
  logic [DW-1:0] exp_q[$], seen[$];
  assign fifo_valid = fifo_en && rd != wr;
  assign fifo_data  = mem[rd % 16];
  always #5 clk = ~clk;
  fifo_stream_reader #(.DATA_WIDTH(DW), .PAR_READ(P), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total_len(total_len),
    .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_ren(fifo_ren),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .elem_count(elem_count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask
  // Model: phase 0 idle, 1 transferring, 2 done pulse; the stream is the lanes of popped words in order.
  task automatic compare(output logic pop);
    logic hs;
    pop = 1'b0;
    if (!rst_n) begin
      chk("rst_ctl", {fifo_ren, out_valid, busy, done}, 0);
      chk("rst_data", out_data, 0);
      chk("rst_cnt", elem_count, 0);
      m_ph = 0; m_cnt = 0; exp_q.delete();
      return;
    end
    chk("ren_gated", fifo_ren && !fifo_valid, 0);
    chk("ren_idle", fifo_ren && m_ph != 1, 0);
    chk("busy", busy, m_ph == 1);
    chk("done", done, m_ph == 2);
    chk("count", elem_count, m_cnt);
    chk("valid_in_xfer", out_valid && m_ph != 1, 0);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("data_extra", 1, 0);
      else chk("data", out_data, exp_q[0]);
    end
    pop = fifo_ren && fifo_valid;
    hs  = out_valid && out_ready;
    if (pop) begin
      for (int l = 0; l < P; l++) exp_q.push_back(DW'(fifo_data >> (l * DW)));
      m_pops++;
    end
    if (m_ph == 0) begin
      if (start) begin
        m_cnt = 0; m_len = int'(total_len); m_pops = 0; exp_q.delete();
        m_ph = total_len == 0 ? 2 : 1;
      end
    end else if (m_ph == 1) begin
      if (hs) begin
        seen.push_back(out_data);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_cnt++;
        if (m_cnt == m_len) begin
          m_ph = 2;
          chk("pops", m_pops, (m_len + P - 1) / P);
          exp_q.delete();
        end
      end
    end else m_ph = 0;
  endtask
  task automatic step();
    logic p;
    @(negedge clk);
    compare(p);
    @(posedge clk);
    #1;
    if (p) begin rd++; pops++; end
  endtask
  task automatic push(input logic [DW*P-1:0] w);
    mem[wr % 16] = w;
    wr++;
  endtask
  task automatic run(input bit go, input int len, input logic [15:0] pat, input int spur,
                     output int cyc, output int gaps);
    int idx;
    bit sv;
    idx = 0; sv = 0; cyc = 0; gaps = 0; out_ready = 1'b1;
    if (go) begin
      start = 1; total_len = LW'(len);
      step();
      start = 0;
    end
    while (!done && cyc < 100) begin
      step();
      cyc++;
      start = cyc == spur;
      if (start) total_len = 1;
      if (out_valid) begin
        sv = 1;
        out_ready = idx < 16 ? pat[idx] : 1'b1;
        idx++;
      end else begin
        out_ready = 1'b1;
        if (sv && !done) gaps++;
      end
    end
    start = 0;
    chk("finish", done, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cyc, gaps, p0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) step();
    rst_n = 1;
    step();
    // zero-length transfer: done on the next cycle, no FIFO access
    push(32'h0000_0099);
    p0 = pops;
    start = 1; total_len = 0;
    step();
    start = 0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_cnt", elem_count, 0);
    step();
    chk("z_done_drop", done, 0);
    chk("z_pops", pops - p0, 0);
    rd = wr;
    // two full words, continuous ready
    push(32'h0002_0001); push(32'h0004_0003);
    seen.delete(); p0 = pops;
    run(1, 4, 16'hFFFF, -1, cyc, gaps);
    chk("t1_n", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t1_seq", seen[i], i + 1);
    chk("t1_pops", pops - p0, 2);
    chk("t1_cnt", elem_count, 4);
    chk("t1_busy", busy, 0);
`ifdef READER_PREFETCH_EN
    chk("t1_gaps", gaps, 0);
    chk("t1_cyc", cyc, 5);
`else
    chk("t1_gaps", gaps, 1);
    chk("t1_cyc", cyc, 6);
`endif
    step();
    chk("t1_done_once", done, 0);
    chk("t1_cnt_hold", elem_count, 4);
    // partial last word; third word must stay in the FIFO
    rd = wr;
    push(32'h000B_000A); push(32'h000D_000C); push(32'h000F_000E);
    seen.delete(); p0 = pops;
    run(1, 3, 16'hFFFF, -1, cyc, gaps);
    chk("t2_n", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("t2_seq", seen[i], 10 + i);
    chk("t2_pops", pops - p0, 2);
    chk("t2_left", wr - rd, 1);
    chk("t2_head", fifo_data, 32'h000F_000E);
    step();
    // downstream stall 1,0,0,1 plus a spurious start while busy
    rd = wr;
    push(32'h0012_0011); push(32'h0014_0013);
    seen.delete(); p0 = pops;
    run(1, 4, 16'hFFF9, 1, cyc, gaps);
    chk("t3_n", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t3_seq", seen[i], 32'h11 + i);
    chk("t3_pops", pops - p0, 2);
    chk("t3_cnt", elem_count, 4);
    step();
    // FIFO empty for 10 cycles in FETCH
    rd = wr; fifo_en = 0;
    push(32'h0022_0021);
    seen.delete(); p0 = pops;
    start = 1; total_len = 2;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_ren_low", fifo_ren, 0);
      chk("t4_valid_low", out_valid, 0);
      step();
    end
    fifo_en = 1;
    #1;
    chk("t4_ren_rise", fifo_ren, 1);
    step();
    chk("t4_resume", out_valid, 1);
    run(0, 0, 16'hFFFF, -1, cyc, gaps);
    chk("t4_n", seen.size(), 2);
    for (int i = 0; i < 2 && i < seen.size(); i++) chk("t4_seq", seen[i], 32'h21 + i);
    chk("t4_pops", pops - p0, 1);
    step();
    // async reset mid-EMIT, then a fresh transfer from the remaining words
    rd = wr;
    push(32'h0032_0031); push(32'h0034_0033); push(32'h0036_0035); push(32'h0038_0037);
    start = 1; total_len = 8;
    step();
    start = 0;
    for (int i = 0; i < 50 && elem_count != 3; i++) step();
    chk("t6_reach3", elem_count, 3);
    chk("t6_emit", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_ctl", {fifo_ren, out_valid, busy, done}, 0);
    chk("t6_rst_cnt", elem_count, 0);
    chk("t6_rst_data", out_data, 0);
    step();
    rst_n = 1;
    seen.delete(); p0 = pops;
    run(1, 2, 16'hFFFF, -1, cyc, gaps);
    chk("t6_n", seen.size(), 2);
    for (int i = 0; i < 2 && i < seen.size(); i++) chk("t6_seq", seen[i], 32'h35 + i);
    chk("t6_pops", pops - p0, 1);
    chk("t6_cnt", elem_count, 2);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
